// File: rtl/mem_pkg.sv
`timescale 1ns/1ps
// mem_pkg
// Shared encodings for the data-memory responder.
//   - ls_type size field encodings (bits [1:0]) and the position of the
//     unsigned-load flag (bit 2).
//   - FSM state encodings used by the responder's handshake controller.
package mem_pkg;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b11;
  localparam int LS_UNSIGNED_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_lane_unit.sv
`timescale 1ns/1ps
// mem_lane_unit
// Combinational byte-lane logic for a little-endian 32-bit data memory.
// Ports:
//   addr_lo    in  2   byte lane of the access (addr[1:0])
//   ls_type    in  3   access size in [1:0], unsigned-load flag in [2]
//   wdata      in  32  store data, right-aligned
//   rword      in  32  current contents of the addressed memory word
//   byte_en    out 4   lanes written by a store
//   wdata_lane out 32  store data replicated so every enabled lane sees it
//   load_data  out 32  extracted and sign/zero-extended load result
//   type_err   out 1   misaligned access or reserved size encoding
module mem_lane_unit
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  ls_type,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] load_data,
  output logic        type_err
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic        is_unsigned;

  assign is_unsigned = ls_type[LS_UNSIGNED_BIT];
  assign byte_val    = rword[{addr_lo, 3'b000} +: 8];
  assign half_val    = addr_lo[1] ? rword[31:16] : rword[15:0];

  // Store data is replicated across the word so the byte enables alone
  // select which lanes change; the load field is extended from its own
  // top bit unless the unsigned flag is set.
  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = 32'h0;
    load_data  = 32'h0;
    type_err   = 1'b0;
    case (ls_type[1:0])
      LS_BYTE: begin
        byte_en    = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        load_data  = is_unsigned ? {24'h0, byte_val}
                                 : {{24{byte_val[7]}}, byte_val};
      end
      LS_HALF: begin
        type_err   = addr_lo[0];
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        load_data  = is_unsigned ? {16'h0, half_val}
                                 : {{16{half_val[15]}}, half_val};
      end
      LS_WORD: begin
        type_err   = (addr_lo != 2'b00);
        byte_en    = 4'b1111;
        wdata_lane = wdata;
        load_data  = rword;
      end
      default: begin
        type_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
`timescale 1ns/1ps
// data_mem_responder
// Data memory for the Memory stage of the MIPS pipeline. One load/store is
// accepted at a time over a req/ack handshake; the access completes after a
// fixed latency, with byte/half/word lane handling and error reporting.
// A separate registered debug port reads whole words for memory dumps.
// Ports:
//   clk        in  1       system clock
//   i_reset    in  1       asynchronous active-high reset
//   i_req      in  1       request valid, held until o_ack
//   i_we       in  1       1 = store, 0 = load
//   i_addr     in  32      byte address
//   i_wdata    in  32      store data
//   i_ls_type  in  3       size in [1:0] (00 byte, 01 half, 11 word), [2] unsigned
//   o_ack      out 1       one-cycle completion pulse
//   o_rdata    out 32      extended load data, valid with o_ack
//   o_err      out 1       access error, valid with o_ack
//   o_busy     out 1       request in flight (pipeline stall)
//   i_dbg_addr in  ADDR_W  debug word index
//   o_dbg_data out 32      registered word at i_dbg_addr
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [2:0]        i_ls_type,
  output logic              o_ack,
  output logic [31:0]       o_rdata,
  output logic              o_err,
  output logic              o_busy,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  output logic [31:0]       o_dbg_data
);

  mem_state_e state;
  mem_state_e state_next;
  logic       commit;
  logic [3:0] cnt;

  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic [2:0]  req_type;

  logic [31:0] mem [DEPTH];

  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       cur_word;
  logic [3:0]        byte_en;
  logic [31:0]       wdata_lane;
  logic [31:0]       load_data;
  logic              type_err;
  logic              range_err;
  logic              access_err;

  assign word_idx   = req_addr[ADDR_W+1:2];
  assign cur_word   = mem[word_idx];
  assign range_err  = |req_addr[31:ADDR_W+2];
  assign access_err = type_err | range_err;

  mem_lane_unit u_lane (
    .addr_lo    (req_addr[1:0]),
    .ls_type    (req_type),
    .wdata      (req_wdata),
    .rword      (cur_word),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .load_data  (load_data),
    .type_err   (type_err)
  );

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The last WAIT cycle (counter at zero) is the commit point: the memory
  // write and the response capture both happen on the edge leaving it.
  always_comb begin
    state_next = state;
    commit     = 1'b0;
    o_ack      = 1'b0;
    o_busy     = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (i_req) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          state_next = ST_RESP;
          commit     = 1'b1;
        end
      end
      ST_RESP: begin
        o_ack      = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // The request is latched on accept so the initiator's inputs are free to
  // change; o_rdata/o_err only move on a commit and hold between acks.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      cnt       <= 4'd0;
      req_addr  <= 32'h0;
      req_wdata <= 32'h0;
      req_we    <= 1'b0;
      req_type  <= 3'b000;
      o_rdata   <= 32'h0;
      o_err     <= 1'b0;
    end else begin
      if (state == ST_IDLE && i_req) begin
        req_addr  <= i_addr;
        req_wdata <= i_wdata;
        req_we    <= i_we;
        req_type  <= i_ls_type;
        cnt       <= 4'(LATENCY - 1);
      end else if (state == ST_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        o_err   <= access_err;
        o_rdata <= (access_err || req_we) ? 32'h0 : load_data;
      end
    end
  end

  // Memory contents survive reset. Because state is cleared asynchronously,
  // a reset before the commit edge leaves commit low and drops the write.
  always_ff @(posedge clk) begin
    if (commit && req_we && !access_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
  end

  // Sampled before any same-edge write lands, so a colliding debug read
  // returns the pre-write word.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      o_dbg_data <= 32'h0;
    end else begin
      o_dbg_data <= mem[i_dbg_addr];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
// tb_data_mem_responder
// Self-checking bench for data_mem_responder: a directed vector table, a
// reset-abort sequence, a debug-port collision sequence, randomized accesses
// against a byte-addressed reference model, and a held-request sequence on a
// second instance built with LATENCY = 1.
module tb_data_mem_responder;

  localparam int DEPTH     = 256;
  localparam int ADDR_W    = 8;
  localparam int LAT       = 2;
  localparam int LAT1      = 1;
  localparam int MEM_BYTES = DEPTH * 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;

  logic              req = 1'b0;
  logic              we = 1'b0;
  logic [31:0]       addr = 32'h0;
  logic [31:0]       wdata = 32'h0;
  logic [2:0]        ls_type = 3'b000;
  logic              ack;
  logic [31:0]       rdata;
  logic              err;
  logic              busy;
  logic [ADDR_W-1:0] dbg_addr = '0;
  logic [31:0]       dbg_data;

  logic              f_req = 1'b0;
  logic              f_we = 1'b0;
  logic [31:0]       f_addr = 32'h0;
  logic [31:0]       f_wdata = 32'h0;
  logic [2:0]        f_ls_type = 3'b000;
  logic              f_ack;
  logic [31:0]       f_rdata;
  logic              f_err;
  logic              f_busy;
  logic [ADDR_W-1:0] f_dbg_addr = '0;
  logic [31:0]       f_dbg_data;

  int total = 0;
  int bad   = 0;

  logic [7:0] mbytes [0:MEM_BYTES-1];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  t;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  data_mem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk        (clk),
    .i_reset    (rst),
    .i_req      (req),
    .i_we       (we),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .i_ls_type  (ls_type),
    .o_ack      (ack),
    .o_rdata    (rdata),
    .o_err      (err),
    .o_busy     (busy),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
  );

  data_mem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LAT1)) dut1 (
    .clk        (clk),
    .i_reset    (rst),
    .i_req      (f_req),
    .i_we       (f_we),
    .i_addr     (f_addr),
    .i_wdata    (f_wdata),
    .i_ls_type  (f_ls_type),
    .o_ack      (f_ack),
    .o_rdata    (f_rdata),
    .o_err      (f_err),
    .o_busy     (f_busy),
    .i_dbg_addr (f_dbg_addr),
    .o_dbg_data (f_dbg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Byte-addressed reference: size from the type, natural alignment, range
  // and reserved-type checks, then byte copy in little-endian order.
  task automatic modelAccess(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] t, output logic [31:0] rd, output logic er);
    int size;
    logic [31:0] v;
    case (t[1:0])
      2'b00:   size = 1;
      2'b01:   size = 2;
      2'b11:   size = 4;
      default: size = 0;
    endcase
    er = 1'b0;
    rd = 32'h0;
    if (size == 0) er = 1'b1;
    else if (a >= 32'(MEM_BYTES)) er = 1'b1;
    else if ((a % 32'(size)) != 0) er = 1'b1;
    if (!er) begin
      if (w) begin
        for (int i = 0; i < size; i++) mbytes[int'(a) + i] = d[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v = v | (32'(mbytes[int'(a) + i]) << (8*i));
        if (size < 4 && !t[2] && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
        rd = v;
      end
    end
  endtask

  // Drives one request on the LATENCY=2 instance starting just after an
  // edge with the DUT idle, holds it until o_ack, and returns the response,
  // the ack latency in cycles after the accept edge (-1 on timeout), and the
  // debug port value seen in the ack cycle.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [2:0] t, output logic [31:0] rd,
                               output logic er, output int lat, output logic [31:0] dbg);
    req = 1'b1; we = w; addr = a; wdata = d; ls_type = t;
    lat = -1; rd = 32'h0; er = 1'b0; dbg = 32'h0;
    @(posedge clk); #1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = c; rd = rdata; er = err; dbg = dbg_data;
        break;
      end
    end
    req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd, mrd, dbg, a, d;
    logic        er, mer, w;
    logic [2:0]  t;
    int          lat, phase;

    for (int i = 0; i < MEM_BYTES; i++) mbytes[i] = 8'h00;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ack",   32'(ack),  32'h0);
    checkOutput("reset_busy",  32'(busy), 32'h0);
    checkOutput("reset_rdata", rdata,     32'h0);
    checkOutput("reset_err",   32'(err),  32'h0);
    checkOutput("reset_dbg",   dbg_data,  32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table: {we, addr, wdata, type, expected rdata, expected err}
    vecs.push_back('{1'b1, 32'h000, 32'h11223344, 3'b011, 32'h00000000, 1'b0});
    vecs.push_back('{1'b1, 32'h008, 32'hCAFEBABE, 3'b011, 32'h00000000, 1'b0});
    vecs.push_back('{1'b1, 32'h001, 32'h00000082, 3'b000, 32'h00000000, 1'b0});
    vecs.push_back('{1'b0, 32'h001, 32'hDEADBEEF, 3'b000, 32'hFFFFFF82, 1'b0});
    vecs.push_back('{1'b0, 32'h001, 32'hDEADBEEF, 3'b100, 32'h00000082, 1'b0});
    vecs.push_back('{1'b1, 32'h002, 32'h00008003, 3'b001, 32'h00000000, 1'b0});
    vecs.push_back('{1'b0, 32'h002, 32'hDEADBEEF, 3'b001, 32'hFFFF8003, 1'b0});
    vecs.push_back('{1'b0, 32'h002, 32'hDEADBEEF, 3'b101, 32'h00008003, 1'b0});
    vecs.push_back('{1'b1, 32'h004, 32'h00008084, 3'b011, 32'h00000000, 1'b0});
    vecs.push_back('{1'b0, 32'h004, 32'hDEADBEEF, 3'b011, 32'h00008084, 1'b0});
    vecs.push_back('{1'b0, 32'h005, 32'hDEADBEEF, 3'b001, 32'h00000000, 1'b1});
    vecs.push_back('{1'b0, 32'h006, 32'hDEADBEEF, 3'b011, 32'h00000000, 1'b1});
    vecs.push_back('{1'b0, 32'h400, 32'hDEADBEEF, 3'b011, 32'h00000000, 1'b1});
    vecs.push_back('{1'b1, 32'h004, 32'hFFFFFFFF, 3'b010, 32'h00000000, 1'b1});
    vecs.push_back('{1'b1, 32'h005, 32'h0000FFFF, 3'b001, 32'h00000000, 1'b1});
    vecs.push_back('{1'b0, 32'h004, 32'hDEADBEEF, 3'b111, 32'h00008084, 1'b0});
    vecs.push_back('{1'b0, 32'h000, 32'hDEADBEEF, 3'b000, 32'h00000044, 1'b0});
    vecs.push_back('{1'b0, 32'h003, 32'hDEADBEEF, 3'b000, 32'hFFFFFF80, 1'b0});
    vecs.push_back('{1'b0, 32'h003, 32'hDEADBEEF, 3'b100, 32'h00000080, 1'b0});
    vecs.push_back('{1'b0, 32'h000, 32'hDEADBEEF, 3'b001, 32'hFFFF8244, 1'b0});
    vecs.push_back('{1'b1, 32'h404, 32'h55555555, 3'b011, 32'h00000000, 1'b1});
    vecs.push_back('{1'b0, 32'h000, 32'hDEADBEEF, 3'b011, 32'h80038244, 1'b0});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].t, rd, er, lat, dbg);
      modelAccess(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].t, mrd, mer);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
      checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
    end

    // Debug port: one-cycle registered read
    dbg_addr = 8'd0;
    @(posedge clk); #1;
    checkOutput("dbg_word0", dbg_data, 32'h80038244);
    dbg_addr = 8'd1;
    checkOutput("dbg_word1_not_yet", dbg_data, 32'h80038244);
    @(posedge clk); #1;
    checkOutput("dbg_word1", dbg_data, 32'h00008084);

    // Reset between accept and commit drops the store
    req = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'h12345678; ls_type = 3'b011;
    @(posedge clk); #1;
    checkOutput("abort_busy_before", 32'(busy), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("abort_busy_now", 32'(busy), 32'h0);
    checkOutput("abort_ack_now", 32'(ack), 32'h0);
    req = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_ack_later", 32'(ack), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h8, 32'h0, 3'b011, rd, er, lat, dbg);
    checkOutput("abort_old_value", rd, 32'hCAFEBABE);
    checkOutput("abort_old_err", 32'(er), 32'h0);

    // Debug read colliding with a commit returns the pre-write word
    dbg_addr = 8'd2;
    applyStimulus(1'b1, 32'h8, 32'h0BADF00D, 3'b011, rd, er, lat, dbg);
    modelAccess(1'b1, 32'h8, 32'h0BADF00D, 3'b011, mrd, mer);
    checkOutput("collide_dbg_pre", dbg, 32'hCAFEBABE);
    checkOutput("collide_dbg_post", dbg_data, 32'h0BADF00D);

    // Randomized phase: seed words 16..23, then mixed accesses
    for (int wi = 16; wi < 24; wi++) begin
      d = $urandom;
      applyStimulus(1'b1, 32'(wi * 4), d, 3'b011, rd, er, lat, dbg);
      modelAccess(1'b1, 32'(wi * 4), d, 3'b011, mrd, mer);
      checkOutput($sformatf("seed%0d_err", wi), 32'(er), 32'(mer));
    end
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) a = 32'h400 + 32'($urandom_range(0, 63));
      else a = 32'h40 + 32'($urandom_range(0, 31));
      w = 1'($urandom_range(0, 1));
      t = 3'($urandom_range(0, 7));
      d = $urandom;
      applyStimulus(w, a, d, t, rd, er, lat, dbg);
      modelAccess(w, a, d, t, mrd, mer);
      checkOutput($sformatf("rand%0d_latency", n), 32'(lat), 32'(LAT));
      checkOutput($sformatf("rand%0d_rdata", n), rd, mrd);
      checkOutput($sformatf("rand%0d_err", n), 32'(er), 32'(mer));
    end

    // LATENCY=1 instance with i_req held: each request spends one IDLE
    // accept cycle, LAT1 WAIT cycles and one RESP cycle.
    f_we = 1'b1; f_addr = 32'h4; f_wdata = 32'h00008084; f_ls_type = 3'b011;
    f_req = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      phase = c % (LAT1 + 2);
      checkOutput($sformatf("held%0d_ack", c), 32'(f_ack), 32'(phase == LAT1));
      checkOutput($sformatf("held%0d_busy", c), 32'(f_busy), 32'(phase != LAT1 + 1));
      if (phase == LAT1) begin
        checkOutput($sformatf("held%0d_rdata", c), f_rdata, 32'h0);
        checkOutput($sformatf("held%0d_err", c), 32'(f_err), 32'h0);
      end
    end
    f_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("held_idle_busy", 32'(f_busy), 32'h0);
    f_dbg_addr = 8'd1;
    @(posedge clk); #1;
    checkOutput("held_dbg_word1", f_dbg_data, 32'h00008084);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
